// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam multiplier: the four half-width cross products share one
// HALF x HALF sub-multiplier, one per cycle. Define VEDIC_APPROX_EN for the approx input.
module vedic_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_APPROX_EN
    input  logic               approx,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      r_step;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_out;
    logic            r_out_valid;

    logic [HALF-1:0]   w_sub_a;
    logic [HALF-1:0]   w_sub_b;
    logic [2*HALF-1:0] w_sub_prod;
    logic [PW-1:0]     w_prod_ext;
    logic [PW-1:0]     w_term;
    logic [PW-1:0]     w_sum;
    logic [1:0]        w_first_step;

    // Approx mode is captured by starting the step counter past the low-low term.
`ifdef VEDIC_APPROX_EN
    assign w_first_step = approx ? 2'd1 : 2'd0;
`else
    assign w_first_step = 2'd0;
`endif

    // Operand half selection for the current step.
    always_comb begin
        w_sub_a = r_a[HALF-1:0];
        w_sub_b = r_b[HALF-1:0];
        case (r_step)
            2'd0: begin
                w_sub_a = r_a[HALF-1:0];
                w_sub_b = r_b[HALF-1:0];
            end
            2'd1: begin
                w_sub_a = r_a[WIDTH-1:HALF];
                w_sub_b = r_b[HALF-1:0];
            end
            2'd2: begin
                w_sub_a = r_a[HALF-1:0];
                w_sub_b = r_b[WIDTH-1:HALF];
            end
            default: begin
                w_sub_a = r_a[WIDTH-1:HALF];
                w_sub_b = r_b[WIDTH-1:HALF];
            end
        endcase
    end

    assign w_sub_prod = {{HALF{1'b0}}, w_sub_a} * {{HALF{1'b0}}, w_sub_b};
    assign w_prod_ext = {{WIDTH{1'b0}}, w_sub_prod};

    // Align the cross product to its weight: 0, HALF, HALF, WIDTH.
    always_comb begin
        w_term = w_prod_ext;
        case (r_step)
            2'd0:    w_term = w_prod_ext;
            2'd1:    w_term = w_prod_ext << HALF;
            2'd2:    w_term = w_prod_ext << HALF;
            default: w_term = w_prod_ext << WIDTH;
        endcase
    end

    // 2*WIDTH bits hold (2^WIDTH-1)^2, so the sum never wraps.
    assign w_sum = r_acc + w_term;

    // Control FSM, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_step      <= 2'd0;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_acc       <= {PW{1'b0}};
            r_out       <= {PW{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= {PW{1'b0}};
                        r_step  <= w_first_step;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_out       <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_step      <= 2'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Scoreboard bench for vedic_mult_seq: directed WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
module tb_vedic_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8_n, iv8, ir8, ov8, ordy8;
    logic [7:0]  a8, b8;
    logic [15:0] o8;
    logic        rst4_n, iv4, ir4, ov4, ordy4;
    logic [3:0]  a4, b4;
    logic [7:0]  o4;
`ifdef VEDIC_APPROX_EN
    logic        ap8, ap4;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] q8[$];
    logic [7:0]  q4[$];
    bit done4 = 1'b0;

    vedic_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef VEDIC_APPROX_EN
        .approx(ap8),
`endif
        .out_valid(ov8), .out_ready(ordy8), .out(o8)
    );

    vedic_mult_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
`ifdef VEDIC_APPROX_EN
        .approx(ap4),
`endif
        .out_valid(ov4), .out_ready(ordy4), .out(o4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare on every output handshake.
    always @(negedge clk) begin
        if (rst8_n && ov8 && ordy8) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb8_unexpected: got out 0x%0h, expected no output", o8);
            end else begin
                check("sb8_out", {16'h0000, o8}, {16'h0000, q8.pop_front()});
            end
        end
        if (rst4_n && ov4 && ordy4) begin
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb4_unexpected: got out 0x%0h, expected no output", o4);
            end else begin
                check("sb4_out", {24'h000000, o4}, {24'h000000, q4.pop_front()});
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ap,
                         input logic push, input logic [15:0] exp);
        int t = 0;
        while (!ir8 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ir8) begin
            check("send8_ready_timeout", {31'd0, ir8}, 32'd1);
            return;
        end
        a8 = a;
        b8 = b;
`ifdef VEDIC_APPROX_EN
        ap8 = ap;
`endif
        iv8 = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic run_lat8(input logic [7:0] a, input logic [7:0] b, input logic ap,
                            input logic [15:0] exp, input int lat_exp, input string name);
        int lat = 0;
        send8(a, b, ap, 1'b1, exp);
        while (!ov8 && lat < 20) begin
            check({name, "_in_ready_low"}, {31'd0, ir8}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, lat_exp);
    endtask

    task automatic seq8();
        int t;
        logic seen;
        check("rst8_out", {16'h0000, o8}, 32'h0);
        check("rst8_out_valid", {31'd0, ov8}, 32'd0);
        check("rst8_in_ready", {31'd0, ir8}, 32'd1);

        run_lat8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 4, "max");
        send8(8'h00, 8'hFF, 1'b0, 1'b1, 16'h0000);
        send8(8'h01, 8'h80, 1'b0, 1'b1, 16'h0080);
        send8(8'h0F, 8'hF0, 1'b0, 1'b1, 16'h0E10);
        send8(8'hF0, 8'hF0, 1'b0, 1'b1, 16'hE100);
        send8(8'h80, 8'h80, 1'b0, 1'b1, 16'h4000);
        send8(8'h12, 8'h34, 1'b0, 1'b1, 16'h03A8);

        // Back-pressure: result must hold while the consumer stalls.
        t = 0;
        while (!ir8 && t < 20) begin @(posedge clk); #1; t++; end
        ordy8 = 1'b0;
        send8(8'd13, 8'd11, 1'b0, 1'b1, 16'h008F);
        t = 0;
        while (!ov8 && t < 20) begin @(posedge clk); #1; t++; end
        check("stall_valid_up", {31'd0, ov8}, 32'd1);
        for (int j = 0; j < 6; j++) begin
            if (j == 1) begin
                a8 = 8'd2;
                b8 = 8'd3;
                iv8 = 1'b1;
            end
            check("stall_out_hold", {16'h0000, o8}, 32'h008F);
            check("stall_valid_hold", {31'd0, ov8}, 32'd1);
            check("stall_in_ready_low", {31'd0, ir8}, 32'd0);
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        ordy8 = 1'b1;
        @(posedge clk); #1;
        send8(8'd2, 8'd3, 1'b0, 1'b1, 16'h0006);

        // Reset in the middle of a calculation discards it.
        send8(8'hAB, 8'hCD, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        rst8_n = 1'b0;
        #1;
        check("abort_out", {16'h0000, o8}, 32'h0);
        check("abort_out_valid", {31'd0, ov8}, 32'd0);
        check("abort_in_ready", {31'd0, ir8}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst8_n = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            seen = seen | ov8;
            @(posedge clk); #1;
        end
        check("abort_no_valid", {31'd0, seen}, 32'd0);
        check("abort_in_ready_after", {31'd0, ir8}, 32'd1);
        check("abort_out_after", {16'h0000, o8}, 32'h0);
        send8(8'h10, 8'h10, 1'b0, 1'b1, 16'h0100);

`ifdef VEDIC_APPROX_EN
        run_lat8(8'hFF, 8'hFF, 1'b1, 16'hFD20, 3, "approx1");
        run_lat8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 4, "approx0");
        run_lat8(8'h12, 8'h34, 1'b1, 16'h03A0, 3, "approx_mid");
`endif
    endtask

    task automatic seq4();
        logic [7:0] e;
        int t;
        check("rst4_out", {24'h000000, o4}, 32'h0);
        check("rst4_in_ready", {31'd0, ir4}, 32'd1);
        for (int i = 0; i < 256; i++) begin
            t = 0;
            while (!ir4 && t < 200) begin @(posedge clk); #1; t++; end
            if (!ir4) begin
                check("send4_ready_timeout", {31'd0, ir4}, 32'd1);
                break;
            end
            a4 = i[7:4];
            b4 = i[3:0];
            e = {4'h0, a4} * {4'h0, b4};
            q4.push_back(e);
            iv4 = 1'b1;
            @(posedge clk); #1;
            iv4 = 1'b0;
        end
        done4 = 1'b1;
    endtask

    task automatic stall4();
        int t = 0;
        while (!(done4 && q4.size() == 0) && t < 30000) begin
            @(posedge clk); #1;
            ordy4 = 1'($urandom_range(0, 1));
            t++;
        end
        ordy4 = 1'b1;
    endtask

    initial begin
        int t;
        rst8_n = 1'b0; iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ordy8 = 1'b1;
        rst4_n = 1'b0; iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; ordy4 = 1'b1;
`ifdef VEDIC_APPROX_EN
        ap8 = 1'b0;
        ap4 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst8_n = 1'b1;
        rst4_n = 1'b1;
        fork
            seq8();
            seq4();
            stall4();
        join
        t = 0;
        while ((q8.size() != 0 || q4.size() != 0) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("sb8_drained", q8.size(), 32'd0);
        check("sb4_drained", q4.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
